uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer fed by the baud clock generator's `tx_clk`. It latches a parallel word on request and shifts out a standard UART frame: start bit, data bits LSB first, optional parity, and stop bits. Each bit lasts exactly one `tx_clk` period. All logic runs in the system `clk` domain; `tx_clk` is sampled and edge-detected, never used as a clock.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame, legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `tx_clk` in 1: bit-rate clock from the divider, treated as data.
- `newd` in 1: transmit request; accepted only while `busy`=0.
- `tx_data` in DATA_W: word to send; sampled in the accept cycle.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even; sampled with `tx_data`.
- `tx` out 1: serial line; idles high.
- `busy` out 1: a frame is in progress.
- `donetx` out 1: one-`clk` pulse at the end of a frame.

## Operation
- **Tick generation:** two-flop sample of `tx_clk` (`q1`, `q2`, both reset to 0). `tick = q1 & ~q2`, one `clk` cycle per `tx_clk` rising edge.
- **FSM states:** IDLE, LOAD, DATA, PARITY (macro only), STOP, FINISH. All state-to-state moves except IDLE→LOAD happen only on `tick`.
- **IDLE:** `tx`=1, `busy`=0. On `newd`=1:
  - latch `tx_data` into the shift register and `parity_odd` into a flag;
  - set `busy`<=1;
  - go to LOAD.
- **LOAD:** on tick, `tx`<=0 (start bit), `bitcnt`<=0, go to DATA.
- **DATA:** on tick, `tx`<=`shreg[0]`, shift right by one, increment `bitcnt`.
  - `bitcnt` is `$clog2(DATA_W)` bits wide.
  - After the tick that launches bit DATA_W-1, go to PARITY, or to STOP when parity is compiled out.
- **PARITY:** on tick, `tx`<= XOR of the latched data, XOR the odd flag. Go to STOP.
- **STOP:** on tick, `tx`<=1 and increment `stopcnt`. After STOP_BITS launches, go to FINISH.
- **FINISH:** on tick, `donetx`<=1 for exactly one `clk`, `busy`<=0, go to IDLE.
  - The FINISH tick closes the last stop bit.
- **Frame length:** 1 + DATA_W + P + STOP_BITS bit periods, where P is 1 with parity compiled in and 0 otherwise.
- **Boundary cases:**
  - `newd` while `busy`=1 is ignored. This includes the FINISH-tick cycle. Latched data is never modified mid-frame.
  - `newd` in the cycle after `donetx` is accepted. The start bit waits for the next tick, so back-to-back frames have one extra idle-high bit period between them.
  - `tx_data` changes after acceptance have no effect.
  - Reset mid-frame:
    - next `clk`: `tx`=1, `busy`=0, `donetx`=0, state IDLE;
    - counters, shift register and sync flops cleared;
    - no partial `donetx` pulse.
- **Reset values:** `tx`=1, `busy`=0, `donetx`=0, state IDLE, `bitcnt`=`stopcnt`=0, `q1`=`q2`=0.

## Timing
- `newd` high at edge n: `busy`=1 after edge n.
- `tick` is asserted two `clk` edges after the `tx_clk` rising edge is sampled.
- `tx` changes on the `clk` edge at the end of the tick cycle. All outputs are registered.
- Every bit, including the start bit, spans exactly one `tx_clk` period, ±0 `clk` jitter.
- `donetx` rises one `tx_clk` period after the final stop bit is launched. It coincides with the `busy` fall.
- Start-bit latency from `newd`: between 1 and one `tx_clk` period plus 3 `clk` cycles.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:** PARITY state present; a parity bit is inserted after the data bits; `parity_odd` is honoured.
- **Undefined:** PARITY state and parity logic are absent; `parity_odd` is ignored; DATA goes directly to STOP.

## Test plan
In all scenarios the bench drives `tx_clk` toggling every 4 `clk` (period 8 `clk`).

1. **Reset:** assert `rst` for 3 cycles with `tx_clk` running → `tx`=1, `busy`=0, `donetx`=0 throughout and after release.
2. **Basic frame:** macro off, DATA_W=8, STOP_BITS=1, `newd` with `tx_data`=0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 8 `clk`. One `donetx` pulse 8 `clk` after the stop bit starts. `busy` high for the whole frame.
3. **Parity:** macro on, `tx_data`=0x07.
   - `parity_odd`=0 → parity bit 1.
   - `parity_odd`=1 → parity bit 0.
   - Frame is 11 bits.
4. **Ignored request:** `newd` with 0xFF during the third data bit of a 0x3C frame → serial bits still 0x3C LSB first. Exactly one `donetx`. No second frame.
5. **Reset mid-frame:** pulse `rst` during data bit 3 of 0x55 → `tx`=1 and `busy`=0 the next cycle. No `donetx`. A following `newd` with 0x81 transmits a correct frame.
6. **Two stop bits:** STOP_BITS=2, `tx_data`=0x00 → `tx` low for 9 periods, then high for 2 periods. `donetx` after the second stop period. An immediate re-request with 0x00 shows one idle bit period before the next start bit.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (odd/even chosen per frame by parity_odd).
module uart_tx_serializer #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_clk,
  input  logic              newd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_odd,
  output logic              tx,
  output logic              busy,
  output logic              donetx
);

  localparam int BW = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

  logic [2:0]        r_state;
  logic              r_q1;
  logic              r_q2;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic [BW-1:0]     r_bitcnt;
  logic [1:0]        r_stopcnt;
  logic [DATA_W-1:0] r_shreg;
  logic              w_tick;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
`else
  logic              w_unused;
  assign w_unused = parity_odd;
`endif

  // tx_clk is data here: one tick per sampled rising edge.
  assign w_tick = r_q1 & ~r_q2;

  // NOTE: every register below updates with <= so all reads in this block see the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1      <= 1'b0;
      r_q2      <= 1'b0;
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bitcnt  <= '0;
      r_stopcnt <= '0;
      r_shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_q1   <= tx_clk;
      r_q2   <= r_q1;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (newd) begin
            r_shreg <= tx_data;
`ifdef UART_TX_PARITY_EN
            r_par   <= parity_odd;
`endif
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: if (w_tick) begin
          r_tx      <= 1'b0;
          r_bitcnt  <= '0;
          r_stopcnt <= '0;
          r_state   <= S_DATA;
        end
        S_DATA: if (w_tick) begin
          r_tx     <= r_shreg[0];
          r_shreg  <= r_shreg >> 1;
          r_bitcnt <= r_bitcnt + BW'(1);
`ifdef UART_TX_PARITY_EN
          // Parity folds in each bit as it leaves, seeded with the odd flag.
          r_par    <= r_par ^ r_shreg[0];
          if (r_bitcnt == LAST_BIT) r_state <= S_PARITY;
`else
          if (r_bitcnt == LAST_BIT) r_state <= S_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (w_tick) begin
          r_tx    <= r_par;
          r_state <= S_STOP;
        end
`endif
        S_STOP: if (w_tick) begin
          r_tx      <= 1'b1;
          r_stopcnt <= r_stopcnt + 2'd1;
          if (r_stopcnt == LAST_STOP) r_state <= S_FINISH;
        end
        S_FINISH: if (w_tick) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx     = r_tx;
  assign busy   = r_busy;
  assign donetx = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: expected frames are queued at request time and
// compared bit-by-bit (value and 8-clk hold) by a line monitor per instance.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_clk;
  logic       newd0, newd1;
  logic [7:0] tx_data;
  logic       parity_odd;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done [2] = '{0, 0};
  int exp_done [2] = '{0, 0};
  frame_t q0 [$];
  frame_t q1 [$];

  uart_tx_serializer #(.DATA_W(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_clk(tx_clk), .newd(newd0), .tx_data(tx_data),
    .parity_odd(parity_odd), .tx(tx0), .busy(busy0), .donetx(done0)
  );

  uart_tx_serializer #(.DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_clk(tx_clk), .newd(newd1), .tx_data(tx_data),
    .parity_odd(parity_odd), .tx(tx1), .busy(busy1), .donetx(done1)
  );

  always #5 clk = ~clk;

  initial begin
    tx_clk = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      tx_clk = ~tx_clk;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done0 === 1'b1) n_done[0]++;
    if (done1 === 1'b1) n_done[1]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int idx);
    return (idx == 0) ? tx0 : tx1;
  endfunction

  function automatic logic busy_of(input int idx);
    return (idx == 0) ? busy0 : busy1;
  endfunction

  function automatic logic done_of(input int idx);
    return (idx == 0) ? done0 : done1;
  endfunction

  function automatic frame_t make_frame(input logic [7:0] d, input logic odd, input int stops);
    frame_t f;
    f.bits = '0;
    f.n    = 1;  // start bit is 0
    for (int i = 0; i < 8; i++) begin
      f.bits[f.n] = d[i];
      f.n++;
    end
    if (PAR_EN) begin
      f.bits[f.n] = (^d) ^ odd;
      f.n++;
    end
    for (int i = 0; i < stops; i++) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    return f;
  endfunction

  // Called right after a negedge; holds newd for one clk edge.
  task automatic send(input int idx, input logic [7:0] d, input logic odd, input bit push);
    tx_data    = d;
    parity_odd = odd;
    if (idx == 0) newd0 = 1'b1;
    else          newd1 = 1'b1;
    if (push) begin
      if (idx == 0) q0.push_back(make_frame(d, odd, 1));
      else          q1.push_back(make_frame(d, odd, 2));
    end
    @(negedge clk);
    newd0 = 1'b0;
    newd1 = 1'b0;
    check("busy_after_newd", busy_of(idx), 1);
  endtask

  task automatic wait_done(input int idx, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_of(idx) === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("donetx_seen", seen, 1);
  endtask

  task automatic wait_start(input int idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tx_of(idx) === 1'b0) break;
      @(negedge clk);
    end
    check("start_seen", tx_of(idx), 0);
  endtask

  task automatic monitor(input int idx);
    frame_t f;
    logic   prev = 1'b1;
    logic   cur, v;
    bit     hold_ok, busy_ok, done_early, aborted;
    forever begin
      @(negedge clk);
      cur = tx_of(idx);
      if (rst !== 1'b1 && prev === 1'b1 && cur === 1'b0) begin
        check("frame_expected", (idx == 0) ? (q0.size() != 0) : (q1.size() != 0), 1);
        f.n = 0;
        if (idx == 0 && q0.size() != 0) f = q0.pop_front();
        if (idx == 1 && q1.size() != 0) f = q1.pop_front();
        aborted    = 0;
        busy_ok    = 1;
        done_early = 0;
        v          = 1'b0;
        for (int k = 0; k < f.n && !aborted; k++) begin
          hold_ok = 1;
          for (int c = 0; c < 8; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1;
              break;
            end
            if (c == 0) v = tx_of(idx);
            else if (tx_of(idx) !== v) hold_ok = 0;
            if (busy_of(idx) !== 1'b1) busy_ok = 0;
            if (done_of(idx) !== 1'b0) done_early = 1;
          end
          if (!aborted) begin
            check($sformatf("dut%0d_bit%0d", idx, k), v, f.bits[k]);
            check($sformatf("dut%0d_hold%0d", idx, k), hold_ok, 1);
          end
        end
        if (f.n != 0 && !aborted) begin
          check("busy_in_frame", busy_ok, 1);
          check("donetx_in_frame", done_early, 0);
          @(negedge clk);
          check("donetx_at_frame_end", done_of(idx), 1);
          check("busy_at_frame_end", busy_of(idx), 0);
          check("tx_idle_at_end", tx_of(idx), 1);
          @(negedge clk);
          check("donetx_one_cycle", done_of(idx), 0);
        end
        cur = tx_of(idx);
        if (aborted) cur = 1'b1;
      end
      prev = cur;
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    int t0, d_before;
    rst        = 1'b1;
    newd0      = 1'b0;
    newd1      = 1'b0;
    tx_data    = 8'h00;
    parity_odd = 1'b0;

    // Reset held 3 cycles with tx_clk running.
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", tx0, 1);
      check("rst_busy", busy0, 0);
      check("rst_donetx", done0, 0);
      check("rst_tx2", tx1, 1);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_tx", tx0, 1);
    check("post_rst_busy", busy0, 0);
    check("post_rst_donetx", done0, 0);

    // Basic frame; tx_data changed after acceptance must not matter.
    send(0, 8'hA5, 1'b0, 1);
    exp_done[0]++;
    tx_data = 8'h00;
    wait_done(0, 200);
    repeat (10) @(negedge clk);

    // Parity, even then odd.
    send(0, 8'h07, 1'b0, 1);
    exp_done[0]++;
    wait_done(0, 200);
    repeat (3) @(negedge clk);
    send(0, 8'h07, 1'b1, 1);
    exp_done[0]++;
    wait_done(0, 200);
    repeat (5) @(negedge clk);

    // Request during the third data bit is ignored.
    send(0, 8'h3C, 1'b0, 1);
    exp_done[0]++;
    wait_start(0, 40);
    repeat (26) @(negedge clk);
    send(0, 8'hFF, 1'b0, 0);
    wait_done(0, 200);
    d_before = n_done[0];
    repeat (120) @(negedge clk);
    check("no_second_frame_done", n_done[0], d_before);
    check("idle_after_ignored", busy0, 0);

    // Reset during data bit 3 of 0x55.
    send(0, 8'h55, 1'b0, 1);
    wait_start(0, 40);
    repeat (35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx0, 1);
    check("midrst_busy", busy0, 0);
    check("midrst_donetx", done0, 0);
    @(negedge clk);
    rst = 1'b0;
    d_before = n_done[0];
    repeat (100) @(negedge clk);
    check("midrst_no_donetx", n_done[0], d_before);
    check("midrst_line_idle", tx0, 1);
    send(0, 8'h81, 1'b0, 1);
    exp_done[0]++;
    wait_done(0, 200);
    repeat (5) @(negedge clk);

    // Two stop bits, then immediate re-request one cycle after donetx.
    send(1, 8'h00, 1'b0, 1);
    exp_done[1]++;
    wait_done(1, 200);
    t0 = cyc;
    send(1, 8'h00, 1'b0, 1);
    exp_done[1]++;
    wait_start(1, 40);
    check("idle_gap_clks", cyc - t0, 8);
    wait_done(1, 200);

    repeat (40) @(negedge clk);
    check("dut0_queue_empty", q0.size(), 0);
    check("dut1_queue_empty", q1.size(), 0);
    check("dut0_donetx_count", n_done[0], exp_done[0]);
    check("dut1_donetx_count", n_done[1], exp_done[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
